// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU function codes and forwarding-select encoding for the EX operand stage.
package ex_operand_stage_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned REG_ADDR_W = 2;

  // ALU FUNC codes as presented on the ALU op input.
  typedef enum logic [2:0] {
    FUNC_ADD = 3'd0,
    FUNC_SUB = 3'd1,
    FUNC_AND = 3'd2,
    FUNC_ORR = 3'd3,
    FUNC_NOT = 3'd4,
    FUNC_TCP = 3'd5,
    FUNC_SHL = 3'd6,
    FUNC_SHR = 3'd7
  } func_e;

  // Source chosen for one operand after hazard resolution.
  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/ex_operand_stage_forward_mux.sv
// Operand forwarding mux: picks EX/MEM, then MEM/WB, then the latched register value.
module forward_mux #(
  parameter int unsigned WORD_SIZE  = ex_operand_stage_pkg::WORD_SIZE,
  parameter int unsigned REG_ADDR_W = ex_operand_stage_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] spec,
  input  logic                  use_bit,
  input  logic [WORD_SIZE-1:0]  latched,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WORD_SIZE-1:0]  exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WORD_SIZE-1:0]  memwb_result,
  output logic [WORD_SIZE-1:0]  value
);
  import ex_operand_stage_pkg::*;

  fwd_sel_e sel;

  // Select the youngest matching producer; operands not read by the instruction never forward.
  always_comb begin
    sel = FWD_REG;
    if (use_bit && exmem_reg_write && (exmem_rd == spec))
      sel = FWD_EXMEM;
    else if (use_bit && memwb_reg_write && (memwb_rd == spec))
      sel = FWD_MEMWB;
  end

  // Drive the operand value from the selected source.
  always_comb begin
    value = latched;
    case (sel)
      FWD_EXMEM: value = exmem_result;
      FWD_MEMWB: value = memwb_result;
      default:   value = latched;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
module ex_operand_stage #(
  parameter int unsigned WORD_SIZE  = ex_operand_stage_pkg::WORD_SIZE,
  parameter int unsigned REG_ADDR_W = ex_operand_stage_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [WORD_SIZE-1:0]  id_rs_data,
  input  logic [WORD_SIZE-1:0]  id_rt_data,
  input  logic [WORD_SIZE-1:0]  id_imm,
  input  logic                  id_use_imm,
  input  logic [2:0]            id_alu_op,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WORD_SIZE-1:0]  exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WORD_SIZE-1:0]  memwb_result,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_alu_op,
  output logic [WORD_SIZE-1:0]  ex_in1,
  output logic [WORD_SIZE-1:0]  ex_in2,
  output logic [WORD_SIZE-1:0]  ex_store_data,
  output logic                  load_use_stall
);
  import ex_operand_stage_pkg::*;

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  use_rs_q;
  logic                  use_rt_q;
  logic                  use_imm_q;
  logic [WORD_SIZE-1:0]  rs_val_q;
  logic [WORD_SIZE-1:0]  rt_val_q;
  logic [WORD_SIZE-1:0]  imm_q;
  func_e                 alu_op_q;
  logic                  reg_write_q;
  logic                  mem_read_q;

  logic [WORD_SIZE-1:0]  rs_fwd;
  logic [WORD_SIZE-1:0]  rt_fwd;

  forward_mux #(
    .WORD_SIZE  (WORD_SIZE),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs (
    .spec            (rs_q),
    .use_bit         (use_rs_q),
    .latched         (rs_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (rs_fwd)
  );

  forward_mux #(
    .WORD_SIZE  (WORD_SIZE),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rt (
    .spec            (rt_q),
    .use_bit         (use_rt_q),
    .latched         (rt_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (rt_fwd)
  );

  // Load-use hazard: a valid load in EX writes a register the ID instruction reads.
  // An immediate-form instruction does not read rt, so it cannot hazard on it.
  always_comb begin
    load_use_stall = valid_q && mem_read_q && reg_write_q && id_valid &&
                     ((id_use_rs && (id_rs == rd_q)) ||
                      (id_use_rt && !id_use_imm && (id_rt == rd_q)));
  end

  // Pipeline register update: reset > flush > stall > load-use bubble > load.
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && load_use_stall)) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      use_rs_q    <= 1'b0;
      use_rt_q    <= 1'b0;
      use_imm_q   <= 1'b0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      alu_op_q    <= FUNC_ADD;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (stall) begin
      // Fold any result retiring during the hold into the latched operands,
      // since its producer will have left EX/MEM and MEM/WB by release time.
      rs_val_q <= rs_fwd;
      rt_val_q <= rt_fwd;
    end else begin
      valid_q     <= id_valid;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rd_q        <= id_rd;
      use_rs_q    <= id_use_rs;
      use_rt_q    <= id_use_rt;
      use_imm_q   <= id_use_imm;
      rs_val_q    <= id_rs_data;
      rt_val_q    <= id_rt_data;
      imm_q       <= id_imm;
      alu_op_q    <= func_e'(id_alu_op);
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end

  // Present registered control and forwarded operands to the ALU and memory stage.
  always_comb begin
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_rd         = rd_q;
    ex_alu_op     = alu_op_q;
    ex_in1        = rs_fwd;
    ex_in2        = use_imm_q ? imm_q : rt_fwd;
    ex_store_data = rt_fwd;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expectations, a negedge monitor checks them.
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_op;
  logic        id_reg_write, id_mem_read;
  logic        stall, flush;
  logic        exmem_reg_write;
  logic [1:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [1:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [1:0]  ex_rd;
  logic [2:0]  ex_alu_op;
  logic [15:0] ex_in1, ex_in2, ex_store_data;
  logic        load_use_stall;

  ex_operand_stage #(.WORD_SIZE(16), .REG_ADDR_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_use_imm      (id_use_imm),
    .id_alu_op       (id_alu_op),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .stall           (stall),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_alu_op       (ex_alu_op),
    .ex_in1          (ex_in1),
    .ex_in2          (ex_in2),
    .ex_store_data   (ex_store_data),
    .load_use_stall  (load_use_stall)
  );

  localparam int unsigned F_VALID = 0, F_RW = 1, F_MR = 2, F_RD = 3, F_OP = 4,
                          F_IN1 = 5, F_IN2 = 6, F_ST = 7, F_LU = 8;

  typedef struct {
    string       name;
    int unsigned fld;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual(input int unsigned f);
    case (f)
      F_VALID: actual = {15'd0, ex_valid};
      F_RW:    actual = {15'd0, ex_reg_write};
      F_MR:    actual = {15'd0, ex_mem_read};
      F_RD:    actual = {14'd0, ex_rd};
      F_OP:    actual = {13'd0, ex_alu_op};
      F_IN1:   actual = ex_in1;
      F_IN2:   actual = ex_in2;
      F_ST:    actual = ex_store_data;
      default: actual = {15'd0, load_use_stall};
    endcase
  endfunction

  // Monitor: everything queued for the current cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] a;
      e = sb.pop_front();
      a = actual(e.fld);
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, a, e.exp);
      end
    end
  end

  task automatic want(input string name, input int unsigned fld, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.fld  = fld;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_use_imm = 0; id_alu_op = 0;
    id_reg_write = 0; id_mem_read = 0; stall = 0; flush = 0; reset = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic instr(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                       input logic urs, input logic urt, input logic [15:0] rsd,
                       input logic [15:0] rtd, input logic uimm, input logic [15:0] imm,
                       input logic [2:0] op, input logic rw, input logic mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_use_imm = uimm; id_imm = imm;
    id_alu_op = op; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) tick();

    // Reset state while idle
    idle();
    want("rst_valid", F_VALID, 0); want("rst_rw", F_RW, 0); want("rst_mr", F_MR, 0);
    want("rst_rd", F_RD, 0); want("rst_op", F_OP, 0); want("rst_in1", F_IN1, 0);
    want("rst_in2", F_IN2, 0); want("rst_st", F_ST, 0); want("rst_lu", F_LU, 0);
    tick();

    // ADD r3 <- r1, r2 with no forwarding
    idle(); instr(2'd1, 2'd2, 2'd3, 1, 1, 16'h0005, 16'h0003, 0, 16'h0000, 3'd0, 1, 0);
    want("pre_valid", F_VALID, 0);
    tick();
    idle();
    want("add_valid", F_VALID, 1); want("add_in1", F_IN1, 16'h0005);
    want("add_in2", F_IN2, 16'h0003); want("add_st", F_ST, 16'h0003);
    want("add_rd", F_RD, 3); want("add_rw", F_RW, 1); want("add_op", F_OP, 0);
    tick();

    // SUB with rs=r1, rt=r2; then forwarding priority checks
    idle(); instr(2'd1, 2'd2, 2'd0, 1, 1, 16'h0123, 16'h0456, 0, 16'h0000, 3'd1, 1, 0);
    tick();
    idle(); instr(2'd1, 2'd2, 2'd0, 1, 1, 16'h0123, 16'h0456, 0, 16'h0000, 3'd1, 1, 0);
    exmem_reg_write = 1; exmem_rd = 2'd1; exmem_result = 16'h1111;
    memwb_reg_write = 1; memwb_rd = 2'd1; memwb_result = 16'h2222;
    want("fwd_exmem_in1", F_IN1, 16'h1111); want("fwd_rt_plain", F_IN2, 16'h0456);
    want("sub_op", F_OP, 1);
    tick();
    idle(); instr(2'd1, 2'd2, 2'd0, 1, 1, 16'h0123, 16'h0456, 0, 16'h0000, 3'd1, 1, 0);
    exmem_reg_write = 0; exmem_rd = 2'd1; exmem_result = 16'h1111;
    memwb_reg_write = 1; memwb_rd = 2'd1; memwb_result = 16'h2222;
    want("fwd_memwb_in1", F_IN1, 16'h2222);
    tick();
    // Next ID instruction: immediate form, rs not used
    idle(); instr(2'd1, 2'd2, 2'd0, 0, 1, 16'h0ABC, 16'h0456, 1, 16'h7777, 3'd2, 1, 0);
    exmem_reg_write = 1; exmem_rd = 2'd2; exmem_result = 16'h3333;
    memwb_reg_write = 1; memwb_rd = 2'd2; memwb_result = 16'h4444;
    want("fwd_rt_in1", F_IN1, 16'h0123); want("fwd_rt_in2", F_IN2, 16'h3333);
    want("fwd_rt_st", F_ST, 16'h3333);
    tick();
    idle();
    exmem_reg_write = 1; exmem_rd = 2'd2; exmem_result = 16'h3333;
    memwb_reg_write = 1; memwb_rd = 2'd1; memwb_result = 16'h5555;
    want("imm_in2", F_IN2, 16'h7777); want("imm_st", F_ST, 16'h3333);
    want("nouse_in1", F_IN1, 16'h0ABC);
    tick();

    // Load-use: LWD r2, then ADD reading r2
    idle(); instr(2'd0, 2'd0, 2'd2, 1, 0, 16'h0010, 16'h0000, 1, 16'h0004, 3'd0, 1, 1);
    want("lu_none", F_LU, 0);
    tick();
    idle(); instr(2'd2, 2'd3, 2'd1, 1, 1, 16'hDEAD, 16'h0002, 0, 16'h0000, 3'd0, 1, 0);
    want("lwd_valid", F_VALID, 1); want("lwd_mr", F_MR, 1); want("lu_set", F_LU, 1);
    tick();
    idle(); instr(2'd2, 2'd3, 2'd1, 1, 1, 16'hDEAD, 16'h0002, 0, 16'h0000, 3'd0, 1, 0);
    want("bub_valid", F_VALID, 0); want("bub_mr", F_MR, 0); want("bub_lu", F_LU, 0);
    want("bub_in1", F_IN1, 0); want("bub_in2", F_IN2, 0); want("bub_op", F_OP, 0);
    tick();
    idle();
    memwb_reg_write = 1; memwb_rd = 2'd2; memwb_result = 16'hBEEF;
    want("replay_valid", F_VALID, 1); want("replay_in1", F_IN1, 16'hBEEF);
    want("replay_in2", F_IN2, 16'h0002); want("replay_rd", F_RD, 1);
    tick();

    // Stall hold with a MEM/WB result retiring in the first stalled cycle
    idle(); instr(2'd3, 2'd0, 2'd2, 1, 0, 16'h0001, 16'h0000, 0, 16'h0000, 3'd3, 1, 0);
    tick();
    idle(); instr(2'd0, 2'd0, 2'd1, 1, 0, 16'h9999, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    stall = 1; memwb_reg_write = 1; memwb_rd = 2'd3; memwb_result = 16'h00AA;
    want("stl1_in1", F_IN1, 16'h00AA); want("stl1_valid", F_VALID, 1);
    tick();
    idle(); instr(2'd0, 2'd0, 2'd1, 1, 0, 16'h9999, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    stall = 1;
    want("stl2_in1", F_IN1, 16'h00AA);
    tick();
    idle(); stall = 1;
    want("stl3_in1", F_IN1, 16'h00AA); want("stl3_op", F_OP, 3);
    tick();
    idle();
    want("stl_rel_in1", F_IN1, 16'h00AA); want("stl_rel_rd", F_RD, 2);
    tick();

    // stall + load-use: hold wins, then flush + stall bubbles
    idle(); instr(2'd0, 2'd0, 2'd1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0002, 3'd0, 1, 1);
    tick();
    idle(); instr(2'd1, 2'd0, 2'd0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    stall = 1;
    want("slu1_lu", F_LU, 1); want("slu1_valid", F_VALID, 1);
    tick();
    idle(); instr(2'd1, 2'd0, 2'd0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    stall = 1;
    want("slu2_lu", F_LU, 1); want("slu2_mr", F_MR, 1);
    tick();
    idle(); instr(2'd1, 2'd0, 2'd0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    stall = 1; flush = 1;
    tick();
    idle();
    want("flush_valid", F_VALID, 0); want("flush_rw", F_RW, 0);
    want("flush_mr", F_MR, 0); want("flush_lu", F_LU, 0);
    tick();

    // Reset in the middle of a stall
    idle(); instr(2'd1, 2'd0, 2'd3, 1, 0, 16'h1234, 16'h0000, 0, 16'h0000, 3'd4, 1, 0);
    tick();
    idle(); stall = 1;
    want("pre_rst_in1", F_IN1, 16'h1234);
    tick();
    idle(); stall = 1; reset = 1;
    tick();
    idle(); stall = 1;
    want("midrst_valid", F_VALID, 0); want("midrst_in1", F_IN1, 0);
    want("midrst_rw", F_RW, 0); want("midrst_op", F_OP, 0);
    tick();

    // Immediate-form instruction does not hazard on rt
    idle(); instr(2'd0, 2'd0, 2'd3, 0, 0, 16'h0000, 16'h0000, 1, 16'h0008, 3'd0, 1, 1);
    tick();
    idle(); instr(2'd0, 2'd3, 2'd1, 0, 1, 16'h0000, 16'h0000, 1, 16'h0001, 3'd0, 1, 0);
    want("imm_no_lu", F_LU, 0);
    stall = 1;
    tick();
    idle(); instr(2'd0, 2'd3, 2'd1, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 3'd0, 1, 0);
    want("rt_lu", F_LU, 1);
    stall = 1;
    tick();
    idle(); flush = 1;
    tick();
    idle();

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
